dmem_port_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters:
  - the store queue drain, which writes retired stores from the SQ head;
  - the load unit, which issues cache-miss loads.
- Sequences tagged load transactions and returns load data to the load unit.
- Guarantees retired stores are never starved, so the SQ cannot wedge dispatch.
- Sits between the SQ/load unit and the memory bus model.

---
 rtl/dmem_port_arbiter_pkg.sv | 28 ++
 rtl/dmem_port_arbiter_starve_ctr.sv | 28 ++
 rtl/dmem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package dmem_port_arbiter_pkg;

   localparam int DEF_TAG_W        = 4;
   localparam int DEF_SQ_HIGH_WM   = 6;
   localparam int DEF_STARVE_LIMIT = 8;

   typedef enum logic [1:0] {
      MEM_NONE  = 2'd0,
      MEM_LOAD  = 2'd1,
      MEM_STORE = 2'd2
   } mem_command_t;

   typedef enum logic [1:0] {
      SIZE_BYTE   = 2'd0,
      SIZE_HALF   = 2'd1,
      SIZE_WORD   = 2'd2,
      SIZE_DOUBLE = 2'd3
   } mem_size_t;

   typedef enum logic {
      IDLE    = 1'b0,
      LD_WAIT = 1'b1
   } dmem_arb_state_t;

endpackage

// File: rtl/dmem_port_arbiter_starve_ctr.sv
// Saturating count of consecutive cycles a pending store was denied the port.
// Latency: limit_hit reflects the count registered on the previous edge.
// Backpressure: none; clear wins over increment.
module dmem_starve_ctr #(
   parameter int LIMIT = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic incr,
   input  logic clear,
   output logic limit_hit
);
   localparam int W = $clog2(LIMIT + 1);

   logic [W-1:0] cnt;

   // Count denied cycles, stick at LIMIT, drop to zero on grant or idle SQ.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (incr && (cnt < W'(LIMIT))) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign limit_hit = (cnt >= W'(LIMIT));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory port between SQ drain (stores) and the load unit.
// Latency: commands combinational; load data 1 cycle after the tag match.
// Backpressure: requesters hold until mem_response grants; one load in flight.
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 64,
   parameter int TAG_W        = DEF_TAG_W,
   parameter int CNT_W        = 4,
   parameter int SQ_HIGH_WM   = DEF_SQ_HIGH_WM,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              squash,
   input  logic              st_req,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [DATA_W-1:0] st_data,
   input  logic [1:0]        st_size,
   input  logic [CNT_W-1:0]  st_count,
   output logic              st_grant,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [1:0]        ld_size,
   output logic              ld_grant,
   output logic              ld_resp_valid,
   output logic [DATA_W-1:0] ld_resp_data,
   output logic [1:0]        mem_command,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic [1:0]        mem_size,
   input  logic [TAG_W-1:0]  mem_response,
   input  logic [TAG_W-1:0]  mem_tag,
   input  logic [DATA_W-1:0] mem_data_in,
   output logic              busy
);

   dmem_arb_state_t   state, state_nxt;
   logic [TAG_W-1:0]  out_tag;
   logic              drop;
   logic              starve_hit;
   logic              st_pri;
   logic              st_win;
   logic              ld_win;
   logic              tag_match;
   mem_command_t      cmd;

   dmem_starve_ctr #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clock     (clock),
      .reset     (reset),
      .incr      (st_req && !st_grant),
      .clear     (st_grant || !st_req),
      .limit_hit (starve_hit)
   );

   // Pick the port winner, drive the memory command and grants, compute next state.
   always_comb begin
      state_nxt = state;
      cmd       = MEM_NONE;
      mem_addr  = '0;
      mem_data  = '0;
      mem_size  = '0;
      st_grant  = 1'b0;
      ld_grant  = 1'b0;

      // Stores are forced ahead when the SQ is filling up or a store has waited too long.
      st_pri    = (st_count >= CNT_W'(SQ_HIGH_WM)) || starve_hit;
      // A squashed load never competes; in LD_WAIT only stores may use the port.
      ld_win    = !reset && (state == IDLE) && ld_req && !squash;
      st_win    = !reset && st_req && (st_pri || !ld_win);
      ld_win    = ld_win && !st_win;
      tag_match = (state == LD_WAIT) && (out_tag != '0) && (mem_tag == out_tag);

      if (st_win) begin
         cmd      = MEM_STORE;
         mem_addr = st_addr;
         mem_data = st_data;
         mem_size = st_size;
         st_grant = (mem_response != '0);
      end else if (ld_win) begin
         cmd      = MEM_LOAD;
         mem_addr = ld_addr;
         mem_size = ld_size;
         ld_grant = (mem_response != '0);
      end

      case (state)
         IDLE:    if (ld_grant)  state_nxt = LD_WAIT;
         LD_WAIT: if (tag_match) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign mem_command = cmd;
   assign busy        = (state == LD_WAIT);

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Remember the outstanding load's tag and whether a flush has orphaned it.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_tag <= '0;
         drop    <= 1'b0;
      end else if (ld_grant) begin
         out_tag <= mem_response;
         drop    <= 1'b0;
      end else if ((state == LD_WAIT) && squash) begin
         drop    <= 1'b1;
      end
   end

   // Register returning load data; a squash in the match cycle also suppresses it.
   always_ff @(posedge clock) begin
      if (reset) begin
         ld_resp_valid <= 1'b0;
         ld_resp_data  <= '0;
      end else begin
         ld_resp_valid <= tag_match && !drop && !squash;
         if (tag_match) ld_resp_data <= mem_data_in;
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        squash;
   logic        st_req;
   logic [31:0] st_addr;
   logic [63:0] st_data;
   logic [1:0]  st_size;
   logic [3:0]  st_count;
   logic        st_grant;
   logic        ld_req;
   logic [31:0] ld_addr;
   logic [1:0]  ld_size;
   logic        ld_grant;
   logic        ld_resp_valid;
   logic [63:0] ld_resp_data;
   logic [1:0]  mem_command;
   logic [31:0] mem_addr;
   logic [63:0] mem_data;
   logic [1:0]  mem_size;
   logic [3:0]  mem_response;
   logic [3:0]  mem_tag;
   logic [63:0] mem_data_in;
   logic        busy;

   int n_chk  = 0;
   int n_pass = 0;

   dmem_port_arbiter dut (
      .clock(clock), .reset(reset), .squash(squash),
      .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
      .st_count(st_count), .st_grant(st_grant),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size), .ld_grant(ld_grant),
      .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
      .mem_command(mem_command), .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_size(mem_size), .mem_response(mem_response), .mem_tag(mem_tag),
      .mem_data_in(mem_data_in), .busy(busy)
   );

   always #5 clock = ~clock;

   // ---------------- behavioural reference model ----------------
   bit          m_busy, m_drop, m_rv;
   logic [3:0]  m_tag;
   int          m_starve;
   logic [63:0] m_rd;
   logic [1:0]  e_cmd, e_size;
   logic [31:0] e_addr;
   logic [63:0] e_data;
   bit          e_stg, e_ldg;

   function automatic void model_eval();
      bit store_first, ld_ok, st_wins, ld_wins;
      store_first = (st_count >= 6) || (m_starve >= 8);
      ld_ok   = !reset && !m_busy && ld_req && !squash;
      st_wins = !reset && st_req && (store_first || !ld_ok);
      ld_wins = ld_ok && !st_wins;
      e_cmd  = st_wins ? 2'd2 : (ld_wins ? 2'd1 : 2'd0);
      e_addr = st_wins ? st_addr : (ld_wins ? ld_addr : 32'd0);
      e_data = st_wins ? st_data : 64'd0;
      e_size = st_wins ? st_size : (ld_wins ? ld_size : 2'd0);
      e_stg  = st_wins && (mem_response != 0);
      e_ldg  = ld_wins && (mem_response != 0);
   endfunction

   function automatic void model_advance();
      if (reset) begin
         m_busy = 0; m_drop = 0; m_rv = 0; m_tag = 0; m_starve = 0; m_rd = 0;
         return;
      end
      if (st_req && !e_stg) m_starve = (m_starve < 8) ? m_starve + 1 : 8;
      else                  m_starve = 0;
      m_rv = 0;
      if (m_busy) begin
         if (mem_tag == m_tag) begin
            m_rv   = !m_drop && !squash;
            m_rd   = mem_data_in;
            m_busy = 0;
         end
         if (squash) m_drop = 1;
      end
      if (e_ldg) begin
         m_busy = 1; m_tag = mem_response; m_drop = 0;
      end
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic idle_inputs();
      reset = 0; squash = 0; st_req = 0; st_addr = 0; st_data = 0; st_size = 0;
      st_count = 0; ld_req = 0; ld_addr = 0; ld_size = 0; mem_response = 0;
      mem_tag = 0; mem_data_in = 0;
   endtask

   task automatic settle();
      #2;
      model_eval();
   endtask

   task automatic tick();
      model_eval();
      @(posedge clock);
      model_advance();
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle_inputs();
      reset = 1; st_req = 1; ld_req = 1; mem_response = 4'd3; st_addr = 32'h40; ld_addr = 32'h80;
      settle();
      n_chk++;
      if ({st_grant, ld_grant, mem_command, mem_addr} !== {1'b0, 1'b0, 2'd0, 32'd0})
         $display("FAIL reset_comb: got g=%b%b cmd=%0d addr=%h want 00/0/0", st_grant, ld_grant, mem_command, mem_addr);
      else n_pass++;
      tick(); tick();
      idle_inputs();
      settle();
      n_chk++;
      if ({busy, ld_resp_valid, ld_resp_data, mem_command} !== {1'b0, 1'b0, 64'd0, 2'd0})
         $display("FAIL reset_state: got busy=%b rv=%b rd=%h cmd=%0d want all 0", busy, ld_resp_valid, ld_resp_data, mem_command);
      else n_pass++;
   endtask

   task automatic test_load_basic();
      idle_inputs();
      ld_req = 1; ld_addr = 32'h1000; ld_size = 2'd3; mem_response = 4'd3;
      settle();
      n_chk++;
      if ({ld_grant, st_grant, mem_command, mem_addr, mem_size} !== {1'b1, 1'b0, 2'd1, 32'h1000, 2'd3})
         $display("FAIL load_issue: got lg=%b sg=%b cmd=%0d addr=%h want 1 0 1 1000", ld_grant, st_grant, mem_command, mem_addr);
      else n_pass++;
      tick();
      idle_inputs();
      settle();
      n_chk++;
      if ({busy, ld_grant, mem_command} !== {1'b1, 1'b0, 2'd0})
         $display("FAIL load_busy: got busy=%b lg=%b cmd=%0d want 1 0 0", busy, ld_grant, mem_command);
      else n_pass++;
      tick();
      mem_tag = 4'd3; mem_data_in = 64'hDEAD;
      settle();
      n_chk++;
      if ({busy, ld_resp_valid} !== 2'b10)
         $display("FAIL load_match_cycle: got busy=%b rv=%b want 1 0", busy, ld_resp_valid);
      else n_pass++;
      tick();
      idle_inputs();
      settle();
      n_chk++;
      if ({busy, ld_resp_valid, ld_resp_data} !== {1'b0, 1'b1, 64'hDEAD})
         $display("FAIL load_resp: got busy=%b rv=%b rd=%h want 0 1 dead", busy, ld_resp_valid, ld_resp_data);
      else n_pass++;
      tick();
      settle();
      n_chk++;
      if ({ld_resp_valid, ld_resp_data} !== {1'b0, 64'hDEAD})
         $display("FAIL load_resp_hold: got rv=%b rd=%h want 0 dead", ld_resp_valid, ld_resp_data);
      else n_pass++;
   endtask

   task automatic test_priority();
      idle_inputs();
      st_req = 1; st_addr = 32'h200; st_data = 64'h1234; st_size = 2'd2; st_count = 4'd2;
      ld_req = 1; ld_addr = 32'h300; mem_response = 4'd1;
      settle();
      n_chk++;
      if ({ld_grant, st_grant, mem_command} !== {1'b1, 1'b0, 2'd1})
         $display("FAIL prio_load_wins: got lg=%b sg=%b cmd=%0d want 1 0 1", ld_grant, st_grant, mem_command);
      else n_pass++;
      tick();
      ld_req = 0; mem_response = 0; mem_tag = 4'd1;
      tick();
      mem_tag = 0; ld_req = 1; st_count = 4'd6; mem_response = 4'd1;
      settle();
      n_chk++;
      if ({st_grant, ld_grant, mem_command, mem_addr, mem_data} !== {1'b1, 1'b0, 2'd2, 32'h200, 64'h1234})
         $display("FAIL prio_store_wm: got sg=%b lg=%b cmd=%0d addr=%h data=%h want 1 0 2 200 1234",
                  st_grant, ld_grant, mem_command, mem_addr, mem_data);
      else n_pass++;
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_starve();
      bit ok = 1;
      idle_inputs();
      st_req = 1; st_addr = 32'h500; st_count = 4'd1; ld_req = 1; ld_addr = 32'h600;
      for (int i = 0; i < 8; i++) begin
         settle();
         if (mem_command !== 2'd1 || st_grant !== 1'b0) ok = 0;
         tick();
      end
      n_chk++;
      if (!ok) $display("FAIL starve_denied: a denied cycle showed cmd=%0d sg=%b want 1 0", mem_command, st_grant);
      else n_pass++;
      mem_response = 4'd1;
      settle();
      n_chk++;
      if ({st_grant, ld_grant, mem_command} !== {1'b1, 1'b0, 2'd2})
         $display("FAIL starve_force: got sg=%b lg=%b cmd=%0d want 1 0 2", st_grant, ld_grant, mem_command);
      else n_pass++;
      tick();
      mem_response = 0;
      settle();
      n_chk++;
      if (mem_command !== 2'd1)
         $display("FAIL starve_cleared: got cmd=%0d want 1", mem_command);
      else n_pass++;
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_squash();
      idle_inputs();
      ld_req = 1; ld_addr = 32'h700; mem_response = 4'd5;
      settle();
      n_chk++;
      if (ld_grant !== 1'b1) $display("FAIL squash_issue: got lg=%b want 1", ld_grant);
      else n_pass++;
      tick();
      idle_inputs(); squash = 1;
      tick();
      squash = 0;
      tick();
      mem_tag = 4'd5; mem_data_in = 64'hBEEF;
      settle();
      n_chk++;
      if (busy !== 1'b1) $display("FAIL squash_still_busy: got busy=%b want 1", busy);
      else n_pass++;
      tick();
      idle_inputs();
      settle();
      n_chk++;
      if ({busy, ld_resp_valid} !== 2'b00)
         $display("FAIL squash_dropped: got busy=%b rv=%b want 0 0", busy, ld_resp_valid);
      else n_pass++;
      tick();
   endtask

   task automatic test_ldwait_store();
      idle_inputs();
      ld_req = 1; mem_response = 4'd6;
      tick();
      idle_inputs();
      st_req = 1; st_addr = 32'h900; st_data = 64'hCAFE; mem_response = 4'd2;
      settle();
      n_chk++;
      if ({st_grant, ld_grant, mem_command, busy} !== {1'b1, 1'b0, 2'd2, 1'b1})
         $display("FAIL ldwait_store: got sg=%b lg=%b cmd=%0d busy=%b want 1 0 2 1", st_grant, ld_grant, mem_command, busy);
      else n_pass++;
      tick();
      idle_inputs(); mem_tag = 4'd7;
      tick();
      settle();
      n_chk++;
      if ({busy, ld_resp_valid} !== 2'b10)
         $display("FAIL ldwait_mismatch: got busy=%b rv=%b want 1 0", busy, ld_resp_valid);
      else n_pass++;
      mem_tag = 4'd6; mem_data_in = 64'h77;
      tick();
      idle_inputs();
      settle();
      n_chk++;
      if ({busy, ld_resp_valid, ld_resp_data} !== {1'b0, 1'b1, 64'h77})
         $display("FAIL ldwait_match: got busy=%b rv=%b rd=%h want 0 1 77", busy, ld_resp_valid, ld_resp_data);
      else n_pass++;
      tick();
   endtask

   task automatic test_reset_midwait();
      idle_inputs();
      ld_req = 1; mem_response = 4'd4;
      tick();
      idle_inputs(); reset = 1;
      tick();
      reset = 0; mem_tag = 4'd4; mem_data_in = 64'hF00D;
      settle();
      n_chk++;
      if ({busy, ld_resp_valid, ld_resp_data, mem_command, st_grant, ld_grant} !== {1'b0, 1'b0, 64'd0, 2'd0, 1'b0, 1'b0})
         $display("FAIL midwait_reset: got busy=%b rv=%b rd=%h cmd=%0d want all 0", busy, ld_resp_valid, ld_resp_data, mem_command);
      else n_pass++;
      tick();
      idle_inputs();
      settle();
      n_chk++;
      if ({busy, ld_resp_valid, ld_resp_data} !== {1'b0, 1'b0, 64'd0})
         $display("FAIL midwait_stale_tag: got busy=%b rv=%b rd=%h want 0 0 0", busy, ld_resp_valid, ld_resp_data);
      else n_pass++;
      tick();
   endtask

   task automatic test_random();
      int bad = 0;
      for (int i = 0; i < 400; i++) begin
         reset        = ($urandom_range(0, 60) == 0);
         squash       = ($urandom_range(0, 9) == 0);
         st_req       = $urandom_range(0, 1);
         st_addr      = $urandom;
         st_data      = {$urandom, $urandom};
         st_size      = 2'($urandom_range(0, 3));
         st_count     = 4'($urandom_range(0, 15));
         ld_req       = $urandom_range(0, 1);
         ld_addr      = $urandom;
         ld_size      = 2'($urandom_range(0, 3));
         mem_response = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         case ($urandom_range(0, 2))
            0:       mem_tag = 4'd0;
            1:       mem_tag = m_tag;
            default: mem_tag = 4'($urandom_range(0, 15));
         endcase
         mem_data_in  = {$urandom, $urandom};
         settle();
         n_chk++;
         if ({st_grant, ld_grant, mem_command, mem_size, busy, ld_resp_valid} !==
             {e_stg, e_ldg, e_cmd, e_size, m_busy, m_rv}) begin
            bad++;
            if (bad < 10)
               $display("FAIL rand_ctrl[%0d]: got sg=%b lg=%b cmd=%0d sz=%0d busy=%b rv=%b want %b %b %0d %0d %b %b",
                        i, st_grant, ld_grant, mem_command, mem_size, busy, ld_resp_valid,
                        e_stg, e_ldg, e_cmd, e_size, m_busy, m_rv);
         end else n_pass++;
         n_chk++;
         if ({mem_addr, mem_data, ld_resp_data} !== {e_addr, e_data, m_rd}) begin
            bad++;
            if (bad < 10)
               $display("FAIL rand_data[%0d]: got addr=%h data=%h rd=%h want %h %h %h",
                        i, mem_addr, mem_data, ld_resp_data, e_addr, e_data, m_rd);
         end else n_pass++;
         tick();
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_load_basic();
      test_priority();
      test_starve();
      test_squash();
      test_ldwait_store();
      test_reset_midwait();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
